// File: rtl/operand_fetch.sv
`timescale 1ns/1ps
// operand_fetch
//   Operand-fetch stage between decode and ID/EX. Reads the register file,
//   bypasses a same-cycle writeback, tracks destinations of outstanding
//   multi-cycle (long) operations in a pending mask and stalls on RAW/WAW
//   hazards against them. Output operands and tags are registered.
//
// Ports
//   CLK, RESET            clock, synchronous active-high reset
//   IN_VALID / IN_READY   decoded instruction handshake (IN_READY combinational)
//   IN_RS1, IN_RS2        source indices; IN_USES_RS1/2 mark real reads
//   IN_RD, IN_RD_WRITE    destination index and write enable
//   IN_LONG               result arrives later via the long writeback path
//   RS1, RS2              register-file read addresses (copies of IN_RS1/2)
//   DATA1, DATA2          register-file read data, same cycle
//   WB_VALID/RD/DATA/LONG writeback port; WB_LONG retires a pending entry
//   OUT_VALID / OUT_READY handshake to ID/EX
//   OUT_OP1, OUT_OP2      registered operands
//   OUT_RD, OUT_RD_WRITE, OUT_LONG  registered tags
//   FLUSH                 kill the held output, accept nothing this cycle
module operand_fetch (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        IN_VALID,
   output logic        IN_READY,
   input  logic [4:0]  IN_RS1,
   input  logic [4:0]  IN_RS2,
   input  logic        IN_USES_RS1,
   input  logic        IN_USES_RS2,
   input  logic [4:0]  IN_RD,
   input  logic        IN_RD_WRITE,
   input  logic        IN_LONG,
   output logic [4:0]  RS1,
   output logic [4:0]  RS2,
   input  logic [31:0] DATA1,
   input  logic [31:0] DATA2,
   input  logic        WB_VALID,
   input  logic [4:0]  WB_RD,
   input  logic [31:0] WB_DATA,
   input  logic        WB_LONG,
   output logic        OUT_VALID,
   input  logic        OUT_READY,
   output logic [31:0] OUT_OP1,
   output logic [31:0] OUT_OP2,
   output logic [4:0]  OUT_RD,
   output logic        OUT_RD_WRITE,
   output logic        OUT_LONG,
   input  logic        FLUSH
);

   logic [31:0] pend_q;
   logic [31:0] pend_nxt;
   logic [31:0] clr_vec;
   logic [31:0] set_vec;
   logic [31:0] kill_vec;
   logic        raw1;
   logic        raw2;
   logic        waw;
   logic        accept;
   logic [31:0] op1;
   logic [31:0] op2;

   function automatic logic [31:0] pick_operand(
      input logic        uses,
      input logic [4:0]  idx,
      input logic [31:0] rf_data,
      input logic        wb_valid,
      input logic [4:0]  wb_rd,
      input logic [31:0] wb_data
   );
      if (!uses || idx == 5'd0)
         pick_operand = 32'd0;
      else if (wb_valid && wb_rd == idx)
         pick_operand = wb_data;
      else
         pick_operand = rf_data;
   endfunction

   assign RS1 = IN_RS1;
   assign RS2 = IN_RS2;

   // A long writeback retiring an index in this cycle resolves the hazard
   // immediately, so the dependent instruction is accepted alongside it and
   // picks the value up through the bypass.
   assign clr_vec  = (WB_VALID && WB_LONG && WB_RD != 5'd0) ? (32'd1 << WB_RD) : 32'd0;

   assign raw1     = IN_USES_RS1 && pend_q[IN_RS1] && !clr_vec[IN_RS1];
   assign raw2     = IN_USES_RS2 && pend_q[IN_RS2] && !clr_vec[IN_RS2];
   assign waw      = IN_RD_WRITE && (IN_RD != 5'd0) && pend_q[IN_RD] && !clr_vec[IN_RD];

   assign IN_READY = (!OUT_VALID || OUT_READY) && !raw1 && !raw2 && !waw && !FLUSH && !RESET;
   assign accept   = IN_VALID && IN_READY;

   assign set_vec  = (accept && IN_LONG && IN_RD_WRITE && IN_RD != 5'd0) ? (32'd1 << IN_RD) : 32'd0;

   // Flushing a long op that never issued: its destination will never be
   // written back, so release it here.
   assign kill_vec = (FLUSH && OUT_VALID && OUT_LONG && OUT_RD_WRITE) ? (32'd1 << OUT_RD) : 32'd0;

   // Set after clear so a new long op wins over a retiring one on the same index;
   // bit 0 is forced low since x0 is never pending.
   assign pend_nxt = ((pend_q & ~clr_vec & ~kill_vec) | set_vec) & ~32'd1;

   assign op1 = pick_operand(IN_USES_RS1, IN_RS1, DATA1, WB_VALID, WB_RD, WB_DATA);
   assign op2 = pick_operand(IN_USES_RS2, IN_RS2, DATA2, WB_VALID, WB_RD, WB_DATA);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         pend_q       <= 32'd0;
         OUT_VALID    <= 1'b0;
         OUT_OP1      <= 32'd0;
         OUT_OP2      <= 32'd0;
         OUT_RD       <= 5'd0;
         OUT_RD_WRITE <= 1'b0;
         OUT_LONG     <= 1'b0;
      end else begin
         pend_q <= pend_nxt;
         if (accept) begin
            OUT_VALID    <= 1'b1;
            OUT_OP1      <= op1;
            OUT_OP2      <= op2;
            OUT_RD       <= IN_RD;
            OUT_RD_WRITE <= IN_RD_WRITE;
            OUT_LONG     <= IN_LONG;
         end else if (FLUSH || OUT_READY) begin
            // data registers intentionally keep their last values
            OUT_VALID <= 1'b0;
         end
      end
   end

endmodule
